// File: rtl/mdu_unit.sv
// ============================================================================
// Module      : mdu_unit
// Description : Multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
//               Optional macro MDU_DIVZERO_GUARD_EN: divide-by-zero leaves HI/LO unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        hold,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int         C_MAX_CYC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int         C_CNT_W    = $clog2(C_MAX_CYC + 1);
    localparam logic [2:0] C_OP_MULT  = 3'd1;
    localparam logic [2:0] C_OP_MULTU = 3'd2;
    localparam logic [2:0] C_OP_DIV   = 3'd3;
    localparam logic [2:0] C_OP_DIVU  = 3'd4;
    localparam logic [2:0] C_OP_MTHI  = 3'd5;
    localparam logic [2:0] C_OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic [2:0]           r_op;

    logic                 w_is_md;
    logic                 w_accept;
    logic                 w_mthi;
    logic                 w_mtlo;
    logic                 w_done;
    logic [63:0]          w_prod_s;
    logic [63:0]          w_prod_u;
    logic [31:0]          w_sdiv_b;
    logic [31:0]          w_udiv_b;
    logic [31:0]          w_quo_s;
    logic [31:0]          w_rem_s;
    logic [31:0]          w_quo_u;
    logic [31:0]          w_rem_u;
    logic [31:0]          w_dz_hi;
    logic [31:0]          w_dz_lo;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;

    assign w_is_md = (op != 3'd0) && (op <= C_OP_DIVU);
    assign busy    = r_busy;
    assign hold    = r_busy | (start & w_is_md);
    assign HI      = r_hi;
    assign LO      = r_lo;

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = w_is_md;
                    w_mthi   = (op == C_OP_MTHI);
                    w_mtlo   = (op == C_OP_MTLO);
                end
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt <= C_CNT_W'(1)) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Divisor forced to 1 for /0 (result overridden) and for MIN/-1, where
    // dividing by 1 yields exactly the architected MIN quotient and zero remainder.
    assign w_sdiv_b = ((r_b == 32'd0) || ((r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF)))
                      ? 32'd1 : r_b;
    assign w_udiv_b = (r_b == 32'd0) ? 32'd1 : r_b;

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_quo_s  = $signed(r_a) / $signed(w_sdiv_b);
    assign w_rem_s  = $signed(r_a) % $signed(w_sdiv_b);
    assign w_quo_u  = r_a / w_udiv_b;
    assign w_rem_u  = r_a % w_udiv_b;

`ifdef MDU_DIVZERO_GUARD_EN
    assign w_dz_hi = r_hi;
    assign w_dz_lo = r_lo;
`else
    assign w_dz_hi = r_a;
    assign w_dz_lo = 32'hFFFF_FFFF;
`endif

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            C_OP_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            C_OP_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            C_OP_DIV: begin
                w_res_hi = (r_b == 32'd0) ? w_dz_hi : w_rem_s;
                w_res_lo = (r_b == 32'd0) ? w_dz_lo : w_quo_s;
            end
            C_OP_DIVU: begin
                w_res_hi = (r_b == 32'd0) ? w_dz_hi : w_rem_u;
                w_res_lo = (r_b == 32'd0) ? w_dz_lo : w_quo_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a    <= A;
                r_b    <= B;
                r_op   <= op;
                r_busy <= 1'b1;
                r_cnt  <= ((op == C_OP_MULT) || (op == C_OP_MULTU))
                          ? C_CNT_W'(MULT_CYCLES) : C_CNT_W'(DIV_CYCLES);
            end
            if (w_mthi) r_hi <= A;
            if (w_mtlo) r_lo <= A;
            if (r_state == S_RUN) begin
                r_cnt <= r_cnt - C_CNT_W'(1);
                if (w_done) begin
                    r_busy <= 1'b0;
                    r_hi   <= w_res_hi;
                    r_lo   <= w_res_lo;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of MULT/MULTU, in cycles.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of DIV/DIVU, in cycles.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request valid; qualifies op, A and B in the same cycle.
REQ-006 op  input  3  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 0 and 7 mean NOP.
REQ-007 A  input  32  rs operand (dividend / multiplicand / MTHI/MTLO data).
REQ-008 B  input  32  rt operand (divisor / multiplier).
REQ-009 busy  output  1  registered; high while an operation is in flight.
REQ-010 hold  output  1  combinational: busy | (start & op in 1..4); the stall request to the D-stage hazard unit.
REQ-011 HI  output  32  registered HI register.
REQ-012 LO  output  32  registered LO register.

Function
REQ-013 The block SHALL have two states, IDLE and RUN, with a down-counter cnt wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-014 In IDLE, start with op 1..4 SHALL latch A, B and op, load cnt with the op's cycle count, and set busy=1 at that edge; HI and LO are unchanged.
REQ-015 In IDLE, start with op 5 SHALL write HI=A at that edge; start with op 6 SHALL write LO=A; busy stays 0.
REQ-016 In IDLE, start with op 0 or 7 SHALL have no effect.
REQ-017 In RUN, cnt SHALL decrement each cycle; on the edge where cnt goes 1->0, HI/LO SHALL take the result, busy SHALL fall, and the state SHALL return to IDLE.
REQ-018 busy SHALL stay high for exactly MULT_CYCLES or DIV_CYCLES consecutive cycles after the start edge.
REQ-019 MULT: {HI,LO} = signed 64-bit product of latched A and B; MULTU: unsigned 64-bit product.
REQ-020 DIV: LO = signed quotient truncated toward zero, HI = remainder with the sign of the dividend; DIVU: unsigned quotient and remainder.
REQ-021 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-022 In RUN, start is ignored for all ops, including MTHI/MTLO; the hazard unit guarantees no such issue, and the block does not rely on it.
REQ-023 Results SHALL use only the operands latched at start; changes on A/B during RUN SHALL have no effect.
REQ-024 start accepted on the same cycle busy falls (IDLE next) SHALL be accepted only from the following cycle onward, so there is no back-to-back acceptance at the completion edge.
REQ-025 hold SHALL be 1 in the start cycle of a mult/div op, so the issuing instruction's successors stall without a gap.

Reset
REQ-026 With reset high at a rising edge: state=IDLE, cnt=0, busy=0, HI=0, LO=0.
REQ-027 Reset SHALL take priority over start and completion.
REQ-028 Reset asserted mid-operation SHALL abort the operation and write no result.

Configuration
REQ-029 Macro MDU_DIVZERO_GUARD_EN: when defined, DIV/DIVU with latched B=0 SHALL still run DIV_CYCLES but leave HI and LO unchanged at completion.
REQ-030 Without MDU_DIVZERO_GUARD_EN, divide-by-zero SHALL write LO=32'hFFFFFFFF and HI=latched A.

Verification
REQ-031 Reset, then MULT A=32'hFFFFFFFE (-2), B=3 -> busy high for 5 cycles; at fall, HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
REQ-032 MULTU A=32'hFFFFFFFF, B=2 -> after 5 cycles, HI=1, LO=32'hFFFFFFFE.
REQ-033 DIV A=-7 (32'hFFFFFFF9), B=2 -> busy for 10 cycles; LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; A changed to 0 during RUN gives no change in result.
REQ-034 MTHI A=32'h12345678, then MTLO A=32'h9ABCDEF0 on consecutive cycles -> busy stays 0, HI/LO updated one edge after each; then MTHI with start during a DIVU RUN is ignored.
REQ-035 DIVU A=100, B=0 -> with the macro, HI/LO keep their prior values; without it, LO=32'hFFFFFFFF, HI=100.
REQ-036 Reset asserted at cycle 3 of a MULT -> the next edge gives busy=0, HI=LO=0; no later result write.
